fwd_stall_scoreboard: RTL
=========================

// Module: fwd_stall_scoreboard
// PURPOSE
//  Decode-stage operand forwarding and stall unit for the 5-stage CPU. It generalises forwarding to three producer
//  stages (EXE>MEM>WB) and tracks the multi-cycle mult/div unit with a busy counter. It sits beside the regfile and
//  feeds DE operands and the global stall.
//  Register address MSB marks HI/LO (address 0 never forwards or stalls).
// PARAMETERS
//  DATA_W  32  operand/result width
//  ADDR_W  6   register address width; bit ADDR_W-1 set = HI/LO register
//  MD_LAT  4   mult/div busy cycles after issue (legal 1..255)
// PORTS
//  clk            in   1       clock, rising edge
//  resetn         in   1       asynchronous active-low reset
//  reg_rs_data    in   DATA_W  regfile rs read data
//  reg_rt_data    in   DATA_W  regfile rt read data
//  de_valid       in   1       DE holds a valid instruction
//  de_rs_addr     in   ADDR_W  DE source address rs
//  de_rt_addr     in   ADDR_W  DE source address rt
//  de_md_start    in   1       DE instruction is mult/div (writes HI/LO)
//  exe_reg_en     in   1       EXE writes a register
//  exe_reg_waddr  in   ADDR_W  EXE destination
//  exe_reg_wdata  in   DATA_W  EXE result
//  exe_mem_read   in   1       EXE is a load (data not yet available)
//  mem_reg_en     in   1       MEM writes a register
//  mem_reg_waddr  in   ADDR_W  MEM destination
//  mem_reg_wdata  in   DATA_W  MEM result
//  wb_reg_en      in   1       WB writes a register
//  wb_reg_waddr   in   ADDR_W  WB destination
//  wb_reg_wdata   in   DATA_W  WB result
//  md_cancel      in   1       flush: abort in-flight mult/div
//  de_rs_data     out  DATA_W  forwarded rs operand
//  de_rt_data     out  DATA_W  forwarded rt operand
//  stall          out  1       freeze PC/IF/DE; bubble into EXE
//  md_busy        out  1       mult/div counter nonzero
//  md_done        out  1       one-cycle pulse on counter 1->0
// BEHAVIOUR
//  - Match per stage s: s_reg_en & s_waddr!=0 & de_x_addr==s_waddr (full ADDR_W compare).
//  - Operands (combinational): EXE match ? exe data : MEM match ? mem data : WB match ? wb data : regfile data.
//  - load_use = exe_mem_read & exe_reg_en & exe_waddr!=0 & (rs match | rt match on EXE).
//  - md_haz = md_busy & (de_rs_addr[MSB] | de_rt_addr[MSB] | de_md_start); the HI/LO check applies to both rs and rt.
//  - stall = de_valid & (load_use | md_haz); combinational, zero latency.
//  - md_cnt register, width 8. Priority: md_cancel -> 0; else issue (de_valid & de_md_start & !stall) -> MD_LAT;
//    else cnt!=0 -> cnt-1. md_busy = (cnt!=0).
//  - md_done is registered: 1 on the cycle after cnt goes 1->0 by decrement; it stays 0 on a cancel.
//  - Back-to-back mult/div is impossible: a second start while busy stalls until md_busy=0. It may then issue the
//    same cycle md_busy is 0.
//  - Cancel and start in the same cycle: cancel wins, cnt=0, no issue.
//  - Reset (async, any time, including mid-op): md_cnt=0, md_done=0, md_busy=0. stall=0 unless a load-use is
//    present on the inputs.
//  - de_valid=0: stall=0, counter still decrements; operands still forwarded.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds output stall_cnt (32 bits) and load_stall_cnt (32 bits), both reset to 0.
//    - stall_cnt increments each cycle stall=1; load_stall_cnt increments each cycle stall=1 & load_use.
//    - Both saturate at 32'hFFFFFFFF.
//  HAZ_PERF_CNT_EN undefined: those ports and their registers do not exist; all other behaviour is identical.
// TESTING
//  1 EXE,MEM,WB all write r5 (a,b,c); DE rs=5 -> de_rs_data=a; drop exe_reg_en -> b; drop mem_reg_en -> c.
//  2 rs=0, EXE waddr=0 en=1 data=0xDEAD -> de_rs_data=reg_rs_data, stall=0.
//  3 load in EXE to r7, DE rt=7 -> stall=1 for 1 cycle; next cycle MEM forwards, stall=0.
//  4 MD_LAT=4: issue mult at t0 -> md_busy t1..t4, md_done=1 at t5. DE reads HI (addr 6'h20) at t2 -> stall until t5.
//  5 cancel at t2 with a new mult start the same cycle -> cnt=0, no issue, md_done never pulses.
//  6 resetn low mid-op (cnt=3) -> md_busy=0 immediately. HAZ_PERF_CNT_EN: stall_cnt preset 0xFFFFFFFE plus 3 stalls -> 0xFFFFFFFF.

Source files
------------

// File: rtl/fwd_stall_scoreboard.sv
// fwd_stall_scoreboard: decode-stage operand forwarding and stall unit.
// Forwards from three producer stages (EXE > MEM > WB) and tracks the
// multi-cycle mult/div unit with an 8-bit busy counter.
// Register address MSB selects HI/LO; address 0 never forwards or stalls.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall counters.
module fwd_stall_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] reg_rs_data,
    input  logic [DATA_W-1:0] reg_rt_data,
    input  logic              de_valid,
    input  logic [ADDR_W-1:0] de_rs_addr,
    input  logic [ADDR_W-1:0] de_rt_addr,
    input  logic              de_md_start,
    input  logic              exe_reg_en,
    input  logic [ADDR_W-1:0] exe_reg_waddr,
    input  logic [DATA_W-1:0] exe_reg_wdata,
    input  logic              exe_mem_read,
    input  logic              mem_reg_en,
    input  logic [ADDR_W-1:0] mem_reg_waddr,
    input  logic [DATA_W-1:0] mem_reg_wdata,
    input  logic              wb_reg_en,
    input  logic [ADDR_W-1:0] wb_reg_waddr,
    input  logic [DATA_W-1:0] wb_reg_wdata,
    input  logic              md_cancel,
    output logic [DATA_W-1:0] de_rs_data,
    output logic [DATA_W-1:0] de_rt_data,
    output logic              stall,
    output logic              md_busy,
    output logic              md_done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       load_stall_cnt
`endif
);

    localparam logic [7:0] MD_LAT_C = 8'(MD_LAT);

    logic [7:0] md_cnt_q, md_cnt_d;
    logic       md_done_q, md_done_d;

    logic exe_rs_hit, exe_rt_hit;
    logic mem_rs_hit, mem_rt_hit;
    logic wb_rs_hit, wb_rt_hit;
    logic load_use, md_haz, md_issue;

    // Per-stage address match; a zero destination never matches.
    always_comb begin
        exe_rs_hit = exe_reg_en && (exe_reg_waddr != '0) && (de_rs_addr == exe_reg_waddr);
        exe_rt_hit = exe_reg_en && (exe_reg_waddr != '0) && (de_rt_addr == exe_reg_waddr);
        mem_rs_hit = mem_reg_en && (mem_reg_waddr != '0) && (de_rs_addr == mem_reg_waddr);
        mem_rt_hit = mem_reg_en && (mem_reg_waddr != '0) && (de_rt_addr == mem_reg_waddr);
        wb_rs_hit  = wb_reg_en  && (wb_reg_waddr  != '0) && (de_rs_addr == wb_reg_waddr);
        wb_rt_hit  = wb_reg_en  && (wb_reg_waddr  != '0) && (de_rt_addr == wb_reg_waddr);
    end

    // Operand muxes: youngest producer wins, regfile is the fallback.
    always_comb begin
        de_rs_data = reg_rs_data;
        if (exe_rs_hit)      de_rs_data = exe_reg_wdata;
        else if (mem_rs_hit) de_rs_data = mem_reg_wdata;
        else if (wb_rs_hit)  de_rs_data = wb_reg_wdata;
        de_rt_data = reg_rt_data;
        if (exe_rt_hit)      de_rt_data = exe_reg_wdata;
        else if (mem_rt_hit) de_rt_data = mem_reg_wdata;
        else if (wb_rt_hit)  de_rt_data = wb_reg_wdata;
    end

    // Hazard detection: a load in EXE cannot forward yet, and HI/LO or a
    // new mult/div must wait for the busy unit to drain.
    always_comb begin
        md_busy  = (md_cnt_q != 8'd0);
        load_use = exe_mem_read && (exe_rs_hit || exe_rt_hit);
        md_haz   = md_busy && (de_rs_addr[ADDR_W-1] || de_rt_addr[ADDR_W-1] || de_md_start);
        stall    = de_valid && (load_use || md_haz);
        md_issue = de_valid && de_md_start && !stall;
        md_done  = md_done_q;
    end

    // Busy counter next state: cancel beats issue beats decrement.
    always_comb begin
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        if (md_cancel) begin
            md_cnt_d = 8'd0;
        end else if (md_issue) begin
            md_cnt_d = MD_LAT_C;
        end else if (md_cnt_q != 8'd0) begin
            md_cnt_d  = md_cnt_q - 8'd1;
            md_done_d = (md_cnt_q == 8'd1);
        end
    end

    // Busy counter and done pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            md_cnt_q  <= 8'd0;
            md_done_q <= 1'b0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] load_cnt_q, load_cnt_d;

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        load_cnt_d  = load_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (stall && load_use && (load_cnt_q != 32'hFFFF_FFFF))
            load_cnt_d = load_cnt_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= 32'd0;
            load_cnt_q  <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            load_cnt_q  <= load_cnt_d;
        end
    end

    assign stall_cnt      = stall_cnt_q;
    assign load_stall_cnt = load_cnt_q;
`endif

endmodule
